// File: rtl/can_pkg.sv
// Shared CAN bus constants for the stuffer, CRC and destuffer.
// Stuffer sequencing state lives here so the destuffer can mirror it.
package can_pkg;

   localparam logic CAN_RECESSIVE = 1'b1;
   localparam logic CAN_DOMINANT  = 1'b0;
   localparam int   CAN_STUFF_LEN = 5;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_STUFF = 1'b1
   } stuff_state_t;

endpackage

// File: rtl/can_bit_stuffer.sv
// CAN transmit bit stuffer: inserts a complement bit after a run of
// STUFF_LEN equal bits and forwards CRC-covered bits to the CRC engine.
module can_bit_stuffer
   import can_pkg::*;
#(
   parameter int STUFF_LEN = CAN_STUFF_LEN,
   parameter int CNT_W     = 3
) (
   input  logic clock,
   input  logic reset,
   input  logic bit_tick,
   input  logic in_bit,
   input  logic in_valid,
   input  logic in_stuff,
   input  logic in_crc,
   output logic in_ready,
   output logic tx_bit,
   output logic stuff_bit,
   output logic crc_data,
   output logic crc_enable,
   output logic underrun,
   input  logic clear_err
);

   stuff_state_t state_q, state_d;
   logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
   logic [CNT_W-1:0] run_nxt;
   logic last_q, last_d;
   logic in_region_q, in_region_d;
   logic tx_bit_q, tx_bit_d;
   logic stuff_bit_q, stuff_bit_d;
   logic crc_data_q, crc_data_d;
   logic crc_enable_q, crc_enable_d;
   logic underrun_q, underrun_d;
   logic stuff_tick;
   logic xfer;
   logic idle_tick;

   assign in_ready   = bit_tick & (state_q == ST_RUN);
   assign xfer       = in_valid & in_ready;
   assign stuff_tick = bit_tick & (state_q == ST_STUFF);
   assign idle_tick  = in_ready & ~in_valid;

   // A run only continues if the previous bit was also in the region
   assign run_nxt = (in_bit == last_q && in_region_q) ?
                    run_cnt_q + 1'b1 : CNT_W'(1);

   always_comb begin
      state_d      = state_q;
      run_cnt_d    = run_cnt_q;
      last_d       = last_q;
      in_region_d  = in_region_q;
      tx_bit_d     = tx_bit_q;
      stuff_bit_d  = stuff_bit_q;
      crc_data_d   = crc_data_q;
      crc_enable_d = 1'b0;
      underrun_d   = underrun_q & ~clear_err;
      unique case (1'b1)
         stuff_tick: begin
            tx_bit_d    = ~last_q;
            stuff_bit_d = 1'b1;
            last_d      = ~last_q;
            run_cnt_d   = CNT_W'(1);
            state_d     = ST_RUN;
         end
         xfer: begin
            tx_bit_d     = in_bit;
            stuff_bit_d  = 1'b0;
            crc_data_d   = in_bit;
            crc_enable_d = in_crc;
            last_d       = in_bit;
            if (in_stuff) begin
               run_cnt_d   = run_nxt;
               in_region_d = 1'b1;
               state_d     = (run_nxt == CNT_W'(STUFF_LEN)) ?
                             ST_STUFF : ST_RUN;
            end else begin
               run_cnt_d   = '0;
               in_region_d = 1'b0;
               state_d     = ST_RUN;
            end
         end
         idle_tick: begin
            tx_bit_d    = CAN_RECESSIVE;
            stuff_bit_d = 1'b0;
            if (in_region_q) underrun_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_RUN;
         run_cnt_q    <= '0;
         last_q       <= CAN_RECESSIVE;
         in_region_q  <= 1'b0;
         tx_bit_q     <= CAN_RECESSIVE;
         stuff_bit_q  <= 1'b0;
         crc_data_q   <= 1'b0;
         crc_enable_q <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         run_cnt_q    <= run_cnt_d;
         last_q       <= last_d;
         in_region_q  <= in_region_d;
         tx_bit_q     <= tx_bit_d;
         stuff_bit_q  <= stuff_bit_d;
         crc_data_q   <= crc_data_d;
         crc_enable_q <= crc_enable_d;
         underrun_q   <= underrun_d;
      end
   end

   assign tx_bit     = tx_bit_q;
   assign stuff_bit  = stuff_bit_q;
   assign crc_data   = crc_data_q;
   assign crc_enable = crc_enable_q;
   assign underrun   = underrun_q;

endmodule

// File: tb/tb_can_bit_stuffer.sv
// Scoreboard bench for can_bit_stuffer: a history-based stuffing model
// predicts every bit-time output; a monitor pops and compares.
module tb_can_bit_stuffer;
   import can_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic bit_tick = 1'b0;
   logic in_bit = 1'b1;
   logic in_valid = 1'b0;
   logic in_stuff = 1'b0;
   logic in_crc = 1'b0;
   logic clear_err = 1'b0;
   logic in_ready, tx_bit, stuff_bit, crc_data, crc_enable, underrun;

   always #5 clock = ~clock;

   can_bit_stuffer dut (
      .clock(clock), .reset(reset), .bit_tick(bit_tick),
      .in_bit(in_bit), .in_valid(in_valid), .in_stuff(in_stuff),
      .in_crc(in_crc), .in_ready(in_ready), .tx_bit(tx_bit),
      .stuff_bit(stuff_bit), .crc_data(crc_data),
      .crc_enable(crc_enable), .underrun(underrun),
      .clear_err(clear_err)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic logic [14:0] crc15(input logic [14:0] c,
                                         input logic b);
      logic f;
      f = b ^ c[14];
      c = {c[13:0], 1'b0};
      if (f) c = c ^ 15'h4599;
      return c;
   endfunction

   // expected output per bit time: {tx, stuff, crc_en, underrun}
   typedef struct packed {
      logic [3:0] v;
      logic       has_cd;
      logic       cd;
   } exp_t;

   exp_t exp_mem [8192];
   int wr_ptr = 0;
   int rd_ptr = 0;

   // model: bits sent on the bus since entering the stuffing region
   bit hist[$];
   bit m_reg = 0, m_pend = 0, m_ur = 0;

   function automatic void push_exp(input logic [3:0] v,
                                    input logic hc, input logic cd);
      exp_t e;
      e.v = v; e.has_cd = hc; e.cd = cd;
      exp_mem[wr_ptr % 8192] = e;
      wr_ptr++;
   endfunction

   function automatic int trail();
      int n = 0;
      for (int i = hist.size() - 1;
           i >= 0 && hist[i] == hist[hist.size()-1]; i--) n++;
      return n;
   endfunction

   function automatic void m_stuff();
      bit s;
      s = ~hist[hist.size()-1];
      hist.push_back(s);
      m_pend = 0;
      push_exp({s, 1'b1, 1'b0, m_ur}, 1'b0, 1'b0);
   endfunction

   function automatic void m_data(input bit b, input bit s, input bit c);
      if (s) begin
         if (!m_reg) hist.delete();
         hist.push_back(b);
         m_reg = 1;
         m_pend = (trail() == CAN_STUFF_LEN);
      end else begin
         hist.delete();
         m_reg = 0;
         m_pend = 0;
      end
      push_exp({b, 1'b0, c, m_ur}, 1'b1, b);
   endfunction

   function automatic void m_idle();
      if (m_pend) m_stuff();
      else begin
         if (m_reg) m_ur = 1;
         push_exp({1'b1, 1'b0, 1'b0, m_ur}, 1'b0, 1'b0);
      end
   endfunction

   // monitor
   bit mon_en = 0;
   bit tick_d = 0;
   bit cbits[$];

   always @(posedge clock) tick_d <= bit_tick & ~reset;

   always @(negedge clock) begin
      exp_t e;
      if (mon_en) begin
         if (crc_enable) cbits.push_back(crc_data);
         if (tick_d) begin
            if (rd_ptr >= wr_ptr) begin
               failures++;
               $display("FAIL sb_underflow actual=tick expected=none");
            end else begin
               e = exp_mem[rd_ptr % 8192];
               rd_ptr++;
               chk("bus_out", {tx_bit, stuff_bit, crc_enable, underrun},
                   e.v);
               if (e.has_cd) chk("crc_data", crc_data, e.cd);
            end
         end else begin
            chk("crc_en_quiet", crc_enable, 1'b0);
         end
      end
   end

   task automatic tick(output bit acc);
      repeat ($urandom_range(0, 2)) begin
         @(posedge clock); #1;
      end
      bit_tick = 1'b1;
      #1 acc = in_valid && in_ready;
      @(posedge clock); #1;
      bit_tick = 1'b0;
   endtask

   bit fq_b[$], fq_s[$], fq_c[$];

   task automatic add(input bit b, input bit s, input bit c);
      fq_b.push_back(b); fq_s.push_back(s); fq_c.push_back(c);
   endtask

   task automatic run_frame(input int gap);
      logic [14:0] rc, dc;
      int nc, start, i, budget;
      bit acc;
      rc = '0; nc = 0; start = cbits.size();
      for (int k = 0; k < fq_b.size(); k++) begin
         if (m_pend) m_stuff();
         m_data(fq_b[k], fq_s[k], fq_c[k]);
         if (fq_c[k]) begin
            rc = crc15(rc, fq_b[k]);
            nc++;
         end
      end
      for (int g = 0; g < gap; g++) m_idle();
      i = 0; budget = 0;
      while (i < fq_b.size()) begin
         in_valid = 1'b1;
         in_bit   = fq_b[i];
         in_stuff = fq_s[i];
         in_crc   = fq_c[i];
         tick(acc);
         if (acc) i++;
         budget++;
         if (budget > 3 * fq_b.size() + 4) begin
            failures++;
            $display("FAIL accept_timeout actual=%0d expected=%0d",
                     i, fq_b.size());
            break;
         end
      end
      in_valid = 1'b0;
      for (int g = 0; g < gap; g++) tick(acc);
      @(negedge clock); #1;
      dc = '0;
      for (int k = start; k < cbits.size(); k++) dc = crc15(dc, cbits[k]);
      chk("crc15", dc, rc);
      chk("crc_pulses", cbits.size() - start, nc);
      chk("sb_drain", rd_ptr, wr_ptr);
      @(posedge clock); #1;
      if (m_ur) begin
         chk("underrun_set", underrun, 1'b1);
         clear_err = 1'b1;
         @(posedge clock); #1;
         clear_err = 1'b0;
         m_ur = 0;
         chk("underrun_clr", underrun, 1'b0);
      end
      fq_b.delete(); fq_s.delete(); fq_c.delete();
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog actual=running expected=done");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      int n, budget, len, k, m;
      bit b;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      chk("rst_state", {tx_bit, stuff_bit, crc_enable, underrun}, 4'b1000);
      chk("rst_crc_data", crc_data, 1'b0);
      chk("rst_ready_idle", in_ready, 1'b0);

      // five dominant bits leave a stuff bit pending, then reset hits
      in_valid = 1'b1; in_stuff = 1'b1; in_crc = 1'b1; in_bit = 1'b0;
      n = 0; budget = 0;
      while (n < 5 && budget < 20) begin
         tick(acc);
         if (acc) n++;
         budget++;
      end
      chk("pre_rst_accepts", n, 5);
      chk("pre_rst_tx", tx_bit, 1'b0);
      reset = 1'b1; bit_tick = 1'b1; in_valid = 1'b0;
      #1 chk("ready_pending", in_ready, 1'b0);
      @(posedge clock); #1;
      chk("mid_rst_state", {tx_bit, stuff_bit, crc_enable, underrun},
          4'b1000);
      reset = 1'b0; bit_tick = 1'b0;
      tick(acc);
      chk("post_rst_tick", {tx_bit, stuff_bit, crc_enable, underrun},
          4'b1000);
      @(posedge clock); #1;
      mon_en = 1;

      // 5 zeros then 1,1
      for (int j = 0; j < 5; j++) add(0, 1, 1);
      add(1, 1, 1); add(1, 1, 1); add(1, 0, 0);
      run_frame(1);
      // chained stuffing
      for (int j = 0; j < 5; j++) add(1, 1, 1);
      for (int j = 0; j < 4; j++) add(0, 1, 1);
      add(1, 0, 0);
      run_frame(2);
      // stuff after last region bit, delimiter delayed
      add(0, 1, 1);
      for (int j = 0; j < 5; j++) add(1, 1, 0);
      add(1, 0, 0);
      run_frame(1);
      // region left open: underrun
      add(0, 1, 1); add(1, 1, 1); add(0, 1, 1);
      run_frame(2);
      // CRC gating on the first 19 bits
      b = 0;
      for (int j = 0; j < 28; j++) begin
         if (j > 0 && $urandom_range(0, 9) < 6) b = ~b;
         add(b, j < 25, j < 19);
      end
      run_frame(1);

      for (int f = 0; f < 30; f++) begin
         len = $urandom_range(12, 40);
         k = $urandom_range(1, len);
         m = k + $urandom_range(0, len - k);
         b = 0;
         for (int j = 0; j < len; j++) begin
            if (j > 0 && $urandom_range(0, 9) < 3) b = ~b;
            add(b, j < m, j < k);
         end
         run_frame($urandom_range(1, 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/can_bit_stuffer.md
Name: can_bit_stuffer

Overview:
- Transmit-side bit stuffer for the CAN controller. It sits between the frame serializer (upstream) and the bus driver (downstream), and feeds the CRC-15 generator in parallel.
- It accepts one unstuffed frame bit per bit time through a valid/ready handshake and drives the bus bit.
- After STUFF_LEN consecutive equal bits inside the stuffing region, it inserts a complementary stuff bit.
- It forwards each accepted CRC-covered bit to the CRC generator as a data bit plus a one-cycle enable.

Parameters:
- STUFF_LEN, 5, run length of equal bits that triggers insertion of a stuff bit.
- CNT_W, 3, width of the run counter; must satisfy 2^CNT_W > STUFF_LEN.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- bit_tick  input  1  one-cycle strobe per CAN bit time; tx_bit advances on this strobe
- in_bit  input  1  unstuffed frame bit from the serializer
- in_valid  input  1  in_bit is valid; in_bit must be held stable until accepted
- in_stuff  input  1  in_bit lies in the stuffing region (SOF through last CRC bit)
- in_crc  input  1  in_bit is covered by the CRC (SOF through data field)
- in_ready  output  1  combinational; equals bit_tick & ~pending
- tx_bit  output  1  registered bus bit; 1 = recessive
- stuff_bit  output  1  registered; high while tx_bit carries an inserted stuff bit
- crc_data  output  1  registered; copy of the accepted in_bit
- crc_enable  output  1  registered one-cycle pulse, aligned with the tx_bit update
- underrun  output  1  sticky; a bit_tick arrived inside the stuffing region with no data available
- clear_err  input  1  clears underrun

Behaviour:
- Reset (dominates every other input): tx_bit=1, stuff_bit=0, crc_data=0, crc_enable=0, underrun=0. Internal state: run_cnt=0, last=1, pending=0, in_region=0.
- Transfer: a transfer occurs when in_valid & in_ready. At most one transfer happens per bit_tick.
- All state updates occur only on cycles where bit_tick=1, with one exception: crc_enable is cleared on every cycle where no transfer occurs.
- On bit_tick, exactly one of the following three cases applies, in priority order.
  a) pending=1 (stuff insertion):
     - tx_bit <= ~last, stuff_bit <= 1, last <= ~last, run_cnt <= 1, pending <= 0.
     - in_ready is 0 in this cycle, so no transfer occurs.
     - The stuff bit counts as the first bit of the new run.
  b) transfer:
     - tx_bit <= in_bit, stuff_bit <= 0, crc_data <= in_bit, crc_enable <= in_crc.
     - If in_stuff=1: new count n = (in_bit==last && in_region) ? run_cnt+1 : 1; run_cnt <= n; last <= in_bit; in_region <= 1; pending <= (n==STUFF_LEN).
     - If in_stuff=0: run_cnt <= 0, in_region <= 0, last <= in_bit, pending <= 0.
  c) no transfer and pending=0 (idle):
     - tx_bit <= 1, stuff_bit <= 0.
     - Run state is unchanged.
     - If in_region=1, underrun <= 1.
- A pending stuff bit raised by the last CRC bit is still inserted on the next bit_tick, even though the next frame bit (CRC delimiter) has in_stuff=0.
- The counter saturates logically at STUFF_LEN and never exceeds it: pending forces the stuff bit before any further data bit is accepted.
- underrun: set as in case c); cleared by clear_err. If set and clear happen in the same cycle, set wins. Only reset or clear_err clears it.
- Latency: an accepted bit appears on tx_bit one clock after its bit_tick. crc_enable pulses in that same clock.
- Stuff bits never assert crc_enable.

Decomposition:
- Shared package can_pkg holds CAN_RECESSIVE=1'b1, CAN_DOMINANT=1'b0 and CAN_STUFF_LEN=5. The can_crc block and the future receive-side destuffer use the same constants.
- No sub-module; this block is a single FSM plus counter.
- The top level connects crc_data and crc_enable directly to the data_in and enable inputs of the CRC-15 generator.

Test Plan:
1. Reset mid-operation: assert reset while pending=1 -> next cycle tx_bit=1, stuff_bit=0, crc_enable=0, underrun=0; no stuff bit after reset is released.
2. Stuff insertion: 5 zeros with in_stuff=1, then 1,1 -> bus sequence 0,0,0,0,0,1(stuff_bit=1),1,1; the run counts the stuff bit as one, so the next 1 makes a run of 2 with no stuff; crc_enable pulses 7 times.
3. Chained stuffing: 5 ones, then 4 zeros -> bus 1,1,1,1,1,0(stuff),0,0,0,0,1(stuff); two stuff insertions in total.
4. Stuff after last CRC bit: 5 ones ending the region, then a delimiter 1 with in_stuff=0 -> bus 1,1,1,1,1,0(stuff),1; delimiter accepted one bit_tick late; in_ready=0 on the stuff tick.
5. Underrun: in_region=1, in_valid=0 on a bit_tick -> tx_bit=1, underrun=1 and stays set; clear_err pulse -> underrun=0.
6. CRC gating: accept bits with in_crc=1 for the first 19 bits (SOF + ID + control), then in_crc=0 -> crc_enable pulses exactly 19 times, none on stuff bits; a CRC block fed in parallel matches a reference CRC-15 (polynomial 0x4599) computed on the unstuffed stream.
